// File: rtl/fixed_point_divider.sv
// -----------------------------------------------------------------------------
// fixed_point_divider
//
// Signed fixed-point divider, Q(WIDTH-FBITS).FBITS operands and result.
// result = trunc_toward_zero((operand_1 << FBITS) / operand_2), computed as an
// unsigned restoring radix-2 division on magnitudes (one quotient bit per
// cycle, WIDTH+FBITS cycles), followed by sign application and saturation.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        synchronous, active-high; forces IDLE and clears outputs
//   start        request pulse, only sampled in IDLE
//   operand_1    dividend (signed fixed-point)
//   operand_2    divisor  (signed fixed-point)
//   result       registered quotient, held until the next completion
//   ready        one-cycle pulse when result/flags are updated
//   busy         high while the iterative division runs
//   div_by_zero  last result came from a zero divisor
//   overflow     last result was saturated
// -----------------------------------------------------------------------------
module fixed_point_divider #(
    parameter int WIDTH = 32,
    parameter int FBITS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic [WIDTH-1:0] result,
    output logic             ready,
    output logic             busy,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int NBITS = WIDTH + FBITS;          // numerator / quotient width
    localparam int CW    = $clog2(NBITS + 1);      // iteration counter width

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    // Largest quotient magnitudes that still fit for each result sign.
    localparam logic [NBITS-1:0] POS_LIM = NBITS'(MAX_VAL);
    localparam logic [NBITS-1:0] NEG_LIM = NBITS'(MIN_VAL);
    localparam logic [CW-1:0]    LAST_IT = CW'(NBITS);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_t;

    state_t state, state_nxt;

    // Division datapath state.
    logic [WIDTH-1:0] divisor_q;   // |operand_2|
    logic [WIDTH:0]   rem_q;       // partial remainder, one spare bit
    logic [NBITS-1:0] quo_q;       // numerator shifts out, quotient shifts in
    logic             neg_q;       // operand signs differ
    logic [CW-1:0]    iter_q;

    // -------------------------------------------------------------------------
    // Operand magnitudes. The most negative value maps to 2^(WIDTH-1), which
    // is representable as an unsigned WIDTH-bit magnitude.
    // -------------------------------------------------------------------------
    logic             op1_neg, op2_neg, div_zero;
    logic [WIDTH-1:0] op1_mag, op2_mag;

    always_comb begin
        op1_neg  = operand_1[WIDTH-1];
        op2_neg  = operand_2[WIDTH-1];
        op1_mag  = op1_neg ? (~operand_1 + WIDTH'(1)) : operand_1;
        op2_mag  = op2_neg ? (~operand_2 + WIDTH'(1)) : operand_2;
        div_zero = (operand_2 == '0);
    end

    // -------------------------------------------------------------------------
    // One restoring step: shift the next numerator bit into the remainder,
    // subtract the divisor if it fits, shift the outcome into the quotient.
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   rem_shift, rem_next;
    logic [NBITS-1:0] quo_next;
    logic             fits;

    always_comb begin
        rem_shift = {rem_q[WIDTH-1:0], quo_q[NBITS-1]};
        fits      = (rem_shift >= {1'b0, divisor_q});
        rem_next  = fits ? (rem_shift - {1'b0, divisor_q}) : rem_shift;
        quo_next  = {quo_q[NBITS-2:0], fits};
    end

    // -------------------------------------------------------------------------
    // Sign application and saturation on the final quotient magnitude.
    // A negative result may reach magnitude 2^(WIDTH-1) without saturating.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] sat_result;
    logic             sat_ovf;

    always_comb begin
        sat_result = quo_q[WIDTH-1:0];
        sat_ovf    = 1'b0;
        if (!neg_q) begin
            if (quo_q > POS_LIM) begin
                sat_result = MAX_VAL;
                sat_ovf    = 1'b1;
            end
        end else begin
            if (quo_q > NEG_LIM) begin
                sat_result = MIN_VAL;
                sat_ovf    = 1'b1;
            end else begin
                sat_result = ~quo_q[WIDTH-1:0] + WIDTH'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // -------------------------------------------------------------------------
    // FSM: next state and status outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                // A zero divisor is resolved at acceptance, so skip DIVIDE.
                if (start) state_nxt = div_zero ? DONE : DIVIDE;
            end
            DIVIDE: begin
                busy = 1'b1;
                // The cycle after the last iteration registers the result.
                if (iter_q == LAST_IT) state_nxt = DONE;
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            neg_q       <= 1'b0;
            iter_q      <= '0;
            result      <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        divisor_q <= op2_mag;
                        rem_q     <= '0;
                        quo_q     <= {op1_mag, {FBITS{1'b0}}};
                        neg_q     <= op1_neg ^ op2_neg;
                        iter_q    <= '0;
                        if (div_zero) begin
                            result      <= op1_neg ? MIN_VAL : MAX_VAL;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end
                    end
                end
                DIVIDE: begin
                    if (iter_q != LAST_IT) begin
                        rem_q  <= rem_next;
                        quo_q  <= quo_next;
                        iter_q <= iter_q + CW'(1);
                    end else begin
                        result      <= sat_result;
                        overflow    <= sat_ovf;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fixed_point_divider.md
FIXED_POINT_DIVIDER -- requirements
Module: fixed_point_divider

Interface
REQ-001 Parameter WIDTH, 32, operand/result width in bits; signed two's complement fixed-point.
REQ-002 Parameter FBITS, 10, fractional bits (Q(WIDTH-FBITS).FBITS format).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 operand_1  input  WIDTH  dividend.
REQ-007 operand_2  input  WIDTH  divisor.
REQ-008 result  output  WIDTH  quotient, registered.
REQ-009 ready  output  1  result valid; single-cycle pulse.
REQ-010 busy  output  1  high while a division is in progress.
REQ-011 div_by_zero  output  1  last result came from a zero divisor; valid with ready.
REQ-012 overflow  output  1  last result was saturated; valid with ready.

Function
REQ-013 The block SHALL compute result = trunc_toward_zero((operand_1 * 2^FBITS) / operand_2) in signed fixed-point.
REQ-014 The FSM SHALL have states IDLE, DIVIDE, DONE; encoding is free.
REQ-015 IDLE with start=1 SHALL latch operand magnitudes and signs, clear the iteration counter, and go to DIVIDE; busy=1 from the next cycle.
REQ-016 DIVIDE SHALL run unsigned restoring radix-2 division over a (WIDTH+FBITS)-bit numerator (|operand_1| << FBITS), one quotient bit per cycle, for exactly WIDTH+FBITS cycles.
REQ-017 After the last iteration, the block SHALL go to DONE, apply sign (negate if operand signs differ) and saturation, and register result.
REQ-018 In DONE, ready SHALL be 1 for exactly one cycle, and busy SHALL be 0; the next state SHALL be IDLE.
REQ-019 Latency: ready SHALL be high in the cycle after the (WIDTH+FBITS+1)th rising edge following the edge that sampled start (43 edges at defaults).
REQ-020 Divisor 0 sampled at start: the block SHALL skip DIVIDE and go straight to DONE.
REQ-021 For a zero divisor, result SHALL be 0x7FFFFFFF if dividend >= 0, else 0x80000000, with div_by_zero=1 and overflow=0; ready is high after 1 edge.
REQ-022 A positive quotient magnitude above 2^(WIDTH-1)-1 SHALL saturate result to 0x7FFFFFFF and set overflow=1.
REQ-023 A negative quotient magnitude above 2^(WIDTH-1) SHALL saturate result to 0x80000000 and set overflow=1.
REQ-024 Dividend 0x80000000 SHALL use magnitude 2^(WIDTH-1) without internal overflow.
REQ-025 start SHALL be ignored while busy or in DONE; operand changes after the accepting edge SHALL NOT affect the result.
REQ-026 result, div_by_zero and overflow SHALL hold their values until the next DONE.
REQ-027 start asserted in the IDLE cycle right after DONE SHALL be accepted (back-to-back operation).

Reset
REQ-028 reset=1 at a rising edge SHALL force IDLE and set result=0, ready=0, busy=0, div_by_zero=0, overflow=0; reset has priority over start.
REQ-029 reset mid-DIVIDE SHALL abort the operation with no ready pulse; the next start SHALL run a full-latency division.

Verification
REQ-030 Exact division: operand_1=0x00001800 (6.0), operand_2=0x00000800 (2.0), start -> ready after 43 edges, result=0x00000C00, flags 0.
REQ-031 Truncation: operand_1=0x00000400 (1.0), operand_2=0x00000C00 (3.0) -> result=0x00000155, flags 0.
REQ-032 Signed division: operand_1=0xFFFFE200 (-7.5), operand_2=0x00000800 (2.0) -> result=0xFFFFF100 (-3.75).
REQ-033 Zero divisor: operand_1=0x00001400, operand_2=0 -> ready after 1 edge, result=0x7FFFFFFF, div_by_zero=1.
REQ-034 Overflow: operand_1=0x7FFFFFFF, operand_2=0x00000001 -> result=0x7FFFFFFF, overflow=1.
REQ-034 continued: operand_1=0x80000000 with operand_2=0x00000001 -> result=0x80000000, overflow=1.
REQ-035 Control: reset at iteration 20 -> no ready and all outputs 0; start pulses during busy are ignored; a back-to-back start after DONE is accepted.
